// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and FSM state type for the multi-cycle ALU
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier datapath
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               last,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    end

    // Product as it will stand after the current step, so the final step
    // can be captured by the top in the same cycle it happens.
    assign product = {sum, mplier[WIDTH-1:1]};
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= mcand_in;
            mplier <= mplier_in;
            cnt    <= '0;
        end else if (step) begin
            acc    <= sum[WIDTH:1];
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle ops plus iterative MUL with start/busy/done
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OP,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resul,
    output logic [WIDTH-1:0] resul_hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam int SW = $clog2(WIDTH);

    state_t             state;
    logic               accept;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   c_res;
    logic               c_carry;
    logic               c_ovf;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [SW-1:0]      shamt;

    assign accept = start && !busy;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && (OP == OP_MUL)),
        .step      (state == S_MUL),
        .mcand_in  (A),
        .mplier_in (B),
        .last      (mul_last),
        .product   (mul_product)
    );

    always_comb begin
        add_w   = {1'b0, A} + {1'b0, B};
        sub_w   = {1'b0, A} - {1'b0, B};
        shamt   = B[SW-1:0];
        c_res   = '0;
        c_carry = 1'b0;
        c_ovf   = 1'b0;
        case (OP)
            OP_ADD: begin
                c_res   = add_w[WIDTH-1:0];
                c_carry = add_w[WIDTH];
                c_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                c_res   = sub_w[WIDTH-1:0];
                c_carry = sub_w[WIDTH];
                c_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: c_res = A & B;
            OP_OR:  c_res = A | B;
            OP_XOR: c_res = A ^ B;
            OP_SLT: c_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL: c_res = A << shamt;
            OP_SRL: c_res = A >> shamt;
            OP_SRA: c_res = $signed(A) >>> shamt;
            default: c_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            resul    <= '0;
            resul_hi <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (OP == OP_MUL) begin
                            state <= S_MUL;
                            busy  <= 1'b1;
                        end else begin
                            done     <= 1'b1;
                            resul    <= c_res;
                            resul_hi <= '0;
                            zero     <= (c_res == '0);
                            carry    <= c_carry;
                            ovf      <= c_ovf;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_last) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        resul    <= mul_product[WIDTH-1:0];
                        resul_hi <= mul_product[2*WIDTH-1:WIDTH];
                        zero     <= (mul_product == '0);
                        carry    <= (mul_product[2*WIDTH-1:WIDTH] != '0);
                        ovf      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc at WIDTH=8 with a reference model
module tb_alu_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [3:0] OP = '0;
    logic       busy;
    logic       done;
    logic [7:0] resul;
    logic [7:0] resul_hi;
    logic       zero;
    logic       carry;
    logic       ovf;

    alu_mc #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .OP       (OP),
        .busy     (busy),
        .done     (done),
        .resul    (resul),
        .resul_hi (resul_hi),
        .zero     (zero),
        .carry    (carry),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       due;
        logic [7:0] res;
        logic [7:0] hi;
        logic     z;
        logic     c;
        logic     v;
    } exp_t;

    exp_t sbq[$];
    exp_t held;
    int   cyc = 0;
    logic rst_q = 1'b1;
    int   busy_from = 1;
    int   busy_until = 0;
    int   checks = 0;
    int   errors = 0;
    bit   fin = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(int op, int a, int b);
        exp_t e;
        int sa, sb, sh, r, p;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        e.due = 0; e.hi = 8'h00; e.c = 1'b0; e.v = 1'b0;
        r = 0;
        case (op)
            0: begin
                r = a + b;
                e.c = (r > 255);
                e.v = (sa + sb > 127) || (sa + sb < -128);
            end
            1: begin
                r = a - b;
                e.c = (a < b);
                e.v = (sa - sb > 127) || (sa - sb < -128);
            end
            2: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = (sa < sb) ? 1 : 0;
            7: r = a << sh;
            8: r = a >> sh;
            9: r = sa >>> sh;
            default: r = 0;
        endcase
        e.res = 8'(r);
        e.z = (e.res == 8'h00);
        if (op == 3) begin
            p = a * b;
            e.res = 8'(p);
            e.hi  = 8'(p / 256);
            e.z   = (p == 0);
            e.c   = (p / 256 != 0);
        end
        return e;
    endfunction

    // Monitor: compare against scoreboard on done, otherwise expect held values.
    always @(negedge clk) begin
        if (cyc >= 1 && !fin) begin
            if (rst_q) begin
                chk("reset_done", 16'(done), 16'h0);
                chk("reset_busy", 16'(busy), 16'h0);
                chk("reset_out", {resul_hi, resul}, 16'h0);
                chk("reset_flags", 16'({zero, carry, ovf}), 16'h0);
                held.res = 8'h00; held.hi = 8'h00;
                held.z = 1'b0; held.c = 1'b0; held.v = 1'b0;
            end else begin
                chk("busy", 16'(busy), 16'((busy_from <= cyc) && (cyc <= busy_until)));
                if (sbq.size() > 0 && sbq[0].due == cyc) begin
                    held = sbq.pop_front();
                    chk("done", 16'(done), 16'h1);
                    chk("resul", 16'(resul), 16'(held.res));
                    chk("resul_hi", 16'(resul_hi), 16'(held.hi));
                    chk("flags_zcv", 16'({zero, carry, ovf}), 16'({held.z, held.c, held.v}));
                end else begin
                    chk("no_done", 16'(done), 16'h0);
                    chk("hold_out", {resul_hi, resul}, {held.hi, held.res});
                    chk("hold_flags", 16'({zero, carry, ovf}), 16'({held.z, held.c, held.v}));
                end
            end
        end
    end

    task automatic issue(bit st, int op, int a, int b);
        int c;
        exp_t e;
        @(negedge clk);
        c = cyc;
        start = st;
        OP = 4'(op);
        A = 8'(a);
        B = 8'(b);
        if (st && !((busy_from <= c) && (c <= busy_until))) begin
            e = model(op, a, b);
            if (op == 3) begin
                e.due = c + 9;
                busy_from = c + 1;
                busy_until = c + 8;
            end else begin
                e.due = c + 1;
            end
            sbq.push_back(e);
        end
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        sbq.delete();
        busy_until = cyc;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(1, 0, 8'hFF, 8'h01);
        issue(1, 0, 8'h7F, 8'h01);
        issue(1, 1, 8'h03, 8'h05);
        issue(1, 3, 8'hFF, 8'hFF);
        for (int i = 0; i < 8; i++) issue(i % 2 == 0, 0, 8'h11, 8'h22);
        issue(1, 9, 8'h80, 8'h03);
        issue(1, 6, 8'hFE, 8'h01);
        issue(1, 15, 8'h12, 8'h34);
        issue(0, 0, 0, 0);

        issue(1, 3, 8'hA5, 8'h5A);
        repeat (3) issue(0, 0, 0, 0);
        do_reset(2);
        repeat (12) issue(1, 3, 8'h33, 8'h44) ;
        repeat (10) issue(0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int op;
            op = ($urandom_range(0, 5) == 0) ? 3 : int'($urandom_range(0, 15));
            issue($urandom_range(0, 3) != 0, op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        repeat (12) issue(0, 0, 0, 0);

        @(negedge clk);
        chk("drain", 16'(sbq.size()), 16'h0);
        fin = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
